// File: rtl/mem_pkg.sv
// Shared types and widths for the memory-access (M) stage and its M->W register bank.
// No logic of its own. Holds the FSM state encoding and the packed control bundle.
// No backpressure here; the stall behaviour is implemented by mem_access_stage.
package mem_pkg;

   localparam int WORD_W    = 32;
   localparam int REG_IDX_W = 4;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } mem_state_t;

   // Everything that travels from M to W alongside the result word
   typedef struct packed {
      logic                 pcload;
      logic                 regw;
      logic                 misalign;
      logic [REG_IDX_W-1:0] reg_scr;
      logic [WORD_W-1:0]    address;
   } mw_ctrl_t;

   localparam int MW_CTRL_W = $bits(mw_ctrl_t);

endpackage

// File: rtl/mw_reg.sv
// M->W pipeline register bank: captures control bundle and result when ld is high.
// Latency 1 cycle. When ld is low a bubble is inserted: valid/pcload/regw/misalign clear,
// while the data fields (reg index, result, address) keep their last value.
module mw_reg
   import mem_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ld,
   input  logic [MW_CTRL_W-1:0] ctrl_in,
   input  logic [WORD_W-1:0]    result_in,
   output logic                 valid,
   output logic [MW_CTRL_W-1:0] ctrl_out,
   output logic [WORD_W-1:0]    result
);

   mw_ctrl_t ctrl_new;
   mw_ctrl_t ctrl_q;

   assign ctrl_new = ctrl_in;
   assign ctrl_out = ctrl_q;

   // Capture on ld, otherwise insert a bubble that clears only the qualifying flags
   always_ff @(posedge clk) begin
      if (rst) begin
         valid  <= 1'b0;
         ctrl_q <= '0;
         result <= '0;
      end else if (ld) begin
         valid  <= 1'b1;
         ctrl_q <= ctrl_new;
         result <= result_in;
      end else begin
         valid           <= 1'b0;
         ctrl_q.pcload   <= 1'b0;
         ctrl_q.regw     <= 1'b0;
         ctrl_q.misalign <= 1'b0;
      end
   end

endmodule

// File: rtl/mem_access_stage.sv
// M stage: data-memory access against a synchronous single-port RAM, then hand-off to W.
// Latency 1 cycle for ALU ops and stores; loads take READ_LAT+1 cycles to reach W.
// Loads hold stall_M high for READ_LAT cycles; the upstream bundle must stay stable meanwhile.
module mem_access_stage
   import mem_pkg::*;
#(
   parameter int READ_LAT = 2,
   parameter int ADDR_W   = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 valid_M,
   input  logic                 pcload_M,
   input  logic                 regw_M,
   input  logic                 memw_M,
   input  logic                 regmem_M,
   input  logic [REG_IDX_W-1:0] regScr_M,
   input  logic [WORD_W-1:0]    ALUrslt_M,
   input  logic [WORD_W-1:0]    address_M,
   input  logic [WORD_W-1:0]    wdata_M,
   output logic                 stall_M,
   output logic [ADDR_W-1:0]    ram_addr,
   output logic [WORD_W-1:0]    ram_data,
   output logic                 ram_wren,
   input  logic [WORD_W-1:0]    ram_q,
   output logic                 valid_W,
   output logic                 pcload_W,
   output logic                 regw_W,
   output logic [REG_IDX_W-1:0] regScr_W,
   output logic [WORD_W-1:0]    result_W,
   output logic [WORD_W-1:0]    address_W,
   output logic                 misalign_W
);

   // Counter start value: number of WAIT cycles before DONE
   localparam logic [1:0] LAT_INIT = 2'(READ_LAT - 1);

   mem_state_t           state, state_nxt;
   logic [1:0]           cnt, cnt_nxt;
   logic [ADDR_W-1:0]    addr_q;
   logic [ADDR_W-1:0]    word_addr;
   mw_ctrl_t             m_ctrl, held_ctrl, w_ctrl_in, w_ctrl;
   logic [MW_CTRL_W-1:0] w_ctrl_q;
   logic [WORD_W-1:0]    w_result;
   logic                 w_ld, lat_ld;

   // Upper address bits above the RAM window are dropped, so accesses wrap
   assign word_addr = ALUrslt_M[ADDR_W+1:2];

   assign m_ctrl = '{pcload:   pcload_M,
                     regw:     regw_M,
                     misalign: (memw_M | regmem_M) & (|ALUrslt_M[1:0]),
                     reg_scr:  regScr_M,
                     address:  address_M};

   // State, load countdown and the latched load bundle/address
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         cnt       <= '0;
         addr_q    <= '0;
         held_ctrl <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (lat_ld) begin
            addr_q    <= word_addr;
            held_ctrl <= m_ctrl;
         end
      end
   end

   // Next state, RAM pins, stall and W-capture control; reset forces all pins low
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      stall_M   = 1'b0;
      ram_wren  = 1'b0;
      ram_addr  = addr_q;
      ram_data  = '0;
      w_ld      = 1'b0;
      lat_ld    = 1'b0;
      w_ctrl_in = m_ctrl;
      w_result  = ALUrslt_M;
      case (state)
         RUN: begin
            ram_addr = word_addr;
            ram_data = wdata_M;
            if (valid_M) begin
               if (regmem_M) begin
                  // A load wins over a simultaneous store request: no write
                  stall_M   = 1'b1;
                  lat_ld    = 1'b1;
                  cnt_nxt   = LAT_INIT;
                  state_nxt = (READ_LAT == 1) ? DONE : WAIT;
               end else begin
                  ram_wren = memw_M;
                  w_ld     = 1'b1;
               end
            end
         end
         WAIT: begin
            stall_M = 1'b1;
            cnt_nxt = cnt - 2'd1;
            if (cnt == 2'd1) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            w_ld      = 1'b1;
            w_ctrl_in = held_ctrl;
            w_result  = ram_q;
            state_nxt = RUN;
         end
         default: begin
            state_nxt = RUN;
         end
      endcase
      if (rst) begin
         stall_M  = 1'b0;
         ram_wren = 1'b0;
         ram_addr = '0;
         ram_data = '0;
      end
   end

   mw_reg u_mw_reg (
      .clk       (clk),
      .rst       (rst),
      .ld        (w_ld),
      .ctrl_in   (w_ctrl_in),
      .result_in (w_result),
      .valid     (valid_W),
      .ctrl_out  (w_ctrl_q),
      .result    (result_W)
   );

   assign w_ctrl     = w_ctrl_q;
   assign pcload_W   = w_ctrl.pcload;
   assign regw_W     = w_ctrl.regw;
   assign misalign_W = w_ctrl.misalign;
   assign regScr_W   = w_ctrl.reg_scr;
   assign address_W  = w_ctrl.address;

endmodule
